// File: rtl/alu_result_fifo_if.sv
// Port bundle for alu_result_fifo: ALU-side push stream, consumer-side pop stream, and status.
// The master modport is the environment (ALU plus consumer). The slave modport is the FIFO.
interface alu_result_fifo_if #(
  parameter int DW = 9,
  parameter int FW = 4,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_y;
  logic [FW-1:0] in_f;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_y;
  logic [FW-1:0] out_f;
  logic          out_zero;
  logic          out_carry;
  logic [CW-1:0] count;
  logic          bad_op;

  modport master (
    output in_valid, in_y, in_f, out_ready,
    input  in_ready, out_valid, out_y, out_f, out_zero, out_carry, count, bad_op
  );

  modport slave (
    input  in_valid, in_y, in_f, out_ready,
    output in_ready, out_valid, out_y, out_f, out_zero, out_carry, count, bad_op
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Flop FIFO that buffers ALU {f,y} results. Data appears 1 cycle after the push. in_ready is ~full only, so a pop never frees a slot in the same cycle.
// Define ALU_FIFO_FLAGS_EN to store zero/carry flags per entry. Without it, out_zero and out_carry are tied to 0.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 9,
  parameter int FW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          bad_q;
  logic [DW-1:0] mem_y [DEPTH];
  logic [FW-1:0] mem_f [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      bad_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_y[i] <= '0;
        mem_f[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_y[wr_ptr] <= bus.in_y;
        mem_f[wr_ptr] <= bus.in_f;
        wr_ptr        <= wr_ptr + 1'b1;
        // Codes above 8 are not ALU operations; the entry is kept but flagged.
        if (bus.in_f > FW'(8)) bad_q <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_y     = mem_y[rd_ptr];
  assign bus.out_f     = mem_f[rd_ptr];
  assign bus.count     = cnt;
  assign bus.bad_op    = bad_q;

`ifdef ALU_FIFO_FLAGS_EN
  logic mem_z [DEPTH];
  logic mem_c [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_z[i] <= 1'b0;
        mem_c[i] <= 1'b0;
      end
    end else if (push) begin
      mem_z[wr_ptr] <= (bus.in_y == '0);
      mem_c[wr_ptr] <= bus.in_y[DW-1];
    end
  end

  assign bus.out_zero  = mem_z[rd_ptr];
  assign bus.out_carry = mem_c[rd_ptr];
`else
  assign bus.out_zero  = 1'b0;
  assign bus.out_carry = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, single push, fill/backpressure, wrap, bad_op, mid-stream reset.
module tb_alu_result_fifo;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_result_fifo_if #(.DW(9), .FW(4), .CW(3)) bus_i ();

  alu_result_fifo #(.DEPTH(4), .DW(9), .FW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c);
`ifdef ALU_FIFO_FLAGS_EN
    chk({tag, "_zero"}, 32'(bus_i.out_zero), 32'(z));
    chk({tag, "_carry"}, 32'(bus_i.out_carry), 32'(c));
`else
    chk({tag, "_zero"}, 32'(bus_i.out_zero), 32'(1'b0 & z));
    chk({tag, "_carry"}, 32'(bus_i.out_carry), 32'(1'b0 & c));
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // 1. Reset held for two edges while in_valid is high.
    rst_n           = 1'b0;
    bus_i.in_valid  = 1'b1;
    bus_i.in_y      = 9'h055;
    bus_i.in_f      = 4'd1;
    bus_i.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(bus_i.count), 32'd0);
    chk("rst_out_valid", 32'(bus_i.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus_i.in_ready), 32'd1);
    chk("rst_bad_op", 32'(bus_i.bad_op), 32'd0);
    chk("rst_out_y", 32'(bus_i.out_y), 32'd0);
    chk_flags("rst", 1'b0, 1'b0);

    // 2. Single push.
    rst_n          = 1'b1;
    bus_i.in_valid = 1'b1;
    bus_i.in_y     = 9'h1FE;
    bus_i.in_f     = 4'd5;
    tick();
    bus_i.in_valid = 1'b0;
    chk("single_out_valid", 32'(bus_i.out_valid), 32'd1);
    chk("single_out_y", 32'(bus_i.out_y), 32'h1FE);
    chk("single_out_f", 32'(bus_i.out_f), 32'd5);
    chk("single_count", 32'(bus_i.count), 32'd1);
    chk_flags("single", 1'b0, 1'b1);
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
    chk("single_pop_count", 32'(bus_i.count), 32'd0);
    chk("single_pop_valid", 32'(bus_i.out_valid), 32'd0);

    // 3. Fill to full, then hold a fifth push until space opens.
    bus_i.in_valid = 1'b1;
    bus_i.in_f     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      bus_i.in_y = 9'(3 + 2 * i);
      tick();
    end
    bus_i.in_y = 9'd11;
    chk("fill_count", 32'(bus_i.count), 32'd4);
    chk("fill_in_ready", 32'(bus_i.in_ready), 32'd0);
    tick();
    chk("full_hold_count", 32'(bus_i.count), 32'd4);
    chk("full_hold_head", 32'(bus_i.out_y), 32'd3);
    bus_i.out_ready = 1'b1;
    tick();
    chk("full_pop_count", 32'(bus_i.count), 32'd3);
    chk("full_pop_head", 32'(bus_i.out_y), 32'd5);
    chk("full_pop_in_ready", 32'(bus_i.in_ready), 32'd1);
    tick();
    bus_i.in_valid = 1'b0;
    chk("push11_count", 32'(bus_i.count), 32'd3);
    chk("push11_head", 32'(bus_i.out_y), 32'd7);
    tick();
    chk("drain_head9", 32'(bus_i.out_y), 32'd9);
    chk("drain_count2", 32'(bus_i.count), 32'd2);
    tick();
    chk("drain_head11", 32'(bus_i.out_y), 32'd11);
    chk("drain_count1", 32'(bus_i.count), 32'd1);
    tick();
    chk("drain_empty", 32'(bus_i.out_valid), 32'd0);
    chk("drain_count0", 32'(bus_i.count), 32'd0);
    bus_i.out_ready = 1'b0;

    // 4. Steady push+pop at count 2 across pointer wrap, then push+pop while full.
    bus_i.in_valid = 1'b1;
    bus_i.in_y     = 9'd20;
    tick();
    bus_i.in_y = 9'd21;
    tick();
    chk("steady_pre_count", 32'(bus_i.count), 32'd2);
    bus_i.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_i.in_y = 9'(22 + k);
      tick();
      chk($sformatf("steady_count_%0d", k), 32'(bus_i.count), 32'd2);
      chk($sformatf("steady_head_%0d", k), 32'(bus_i.out_y), 32'(21 + k));
    end
    bus_i.out_ready = 1'b0;
    bus_i.in_y      = 9'd32;
    tick();
    bus_i.in_y = 9'd33;
    tick();
    chk("refill_count", 32'(bus_i.count), 32'd4);
    bus_i.in_y      = 9'd34;
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    chk("full_pushpop_count", 32'(bus_i.count), 32'd3);
    chk("full_pushpop_head", 32'(bus_i.out_y), 32'd31);
    tick();
    chk("wrap_head32", 32'(bus_i.out_y), 32'd32);
    tick();
    chk("wrap_head33", 32'(bus_i.out_y), 32'd33);
    tick();
    chk("wrap_no34", 32'(bus_i.count), 32'd0);
    bus_i.out_ready = 1'b0;

    // 5. bad_op: code 8 is legal, code 10 sets the sticky flag.
    bus_i.in_valid = 1'b1;
    bus_i.in_y     = 9'd1;
    bus_i.in_f     = 4'b1000;
    tick();
    chk("badop_f8", 32'(bus_i.bad_op), 32'd0);
    bus_i.in_y = 9'd0;
    bus_i.in_f = 4'b1010;
    tick();
    chk("badop_set", 32'(bus_i.bad_op), 32'd1);
    chk("badop_count", 32'(bus_i.count), 32'd2);
    bus_i.in_y = 9'd7;
    bus_i.in_f = 4'd2;
    tick();
    bus_i.in_valid = 1'b0;
    chk("badop_sticky", 32'(bus_i.bad_op), 32'd1);
    chk("badop_count3", 32'(bus_i.count), 32'd3);
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
    chk("badop_head_f", 32'(bus_i.out_f), 32'hA);
    chk("badop_head_y", 32'(bus_i.out_y), 32'd0);
    chk_flags("badop_head", 1'b1, 1'b0);
    chk("badop_still", 32'(bus_i.bad_op), 32'd1);
    bus_i.in_valid = 1'b1;
    bus_i.in_y     = 9'd8;
    bus_i.in_f     = 4'd3;
    tick();
    chk("midrst_pre_count", 32'(bus_i.count), 32'd3);

    // 6. Reset with push and pop both active at count 3.
    rst_n           = 1'b0;
    bus_i.in_y      = 9'h099;
    bus_i.in_f      = 4'd1;
    bus_i.out_ready = 1'b1;
    tick();
    chk("midrst_count", 32'(bus_i.count), 32'd0);
    chk("midrst_valid", 32'(bus_i.out_valid), 32'd0);
    chk("midrst_bad_op", 32'(bus_i.bad_op), 32'd0);
    chk("midrst_out_y", 32'(bus_i.out_y), 32'd0);
    rst_n          = 1'b1;
    bus_i.in_valid = 1'b0;
    tick();
    chk("postrst_valid", 32'(bus_i.out_valid), 32'd0);
    chk("postrst_count", 32'(bus_i.count), 32'd0);
    bus_i.out_ready = 1'b0;
    bus_i.in_valid  = 1'b1;
    bus_i.in_y      = 9'h042;
    tick();
    bus_i.in_valid = 1'b0;
    chk("postrst_push_y", 32'(bus_i.out_y), 32'h042);
    chk("postrst_push_count", 32'(bus_i.count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
